clint_tick_ctrl: RTL and testbench

CLINT_TICK_CTRL -- requirements
Module: clint_tick_ctrl

---
 rtl/clint_tick_ctrl_pkg.sv | 31 +++
 rtl/clint_tick_ctrl.sv | 156 +++++++++++++++
 tb/tb_clint_tick_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clint_tick_ctrl_pkg.sv
// Shared constants for the CLINT tick controller: CLINT register map,
// reload sequence states and the period floor helper.
package clint_tick_ctrl_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned OVR_W  = 8;

  localparam logic [WORD_W-1:0] MTIME_LO    = 32'h0000_BFF8;
  localparam logic [WORD_W-1:0] MTIME_HI    = 32'h0000_BFFC;
  localparam logic [WORD_W-1:0] MTIMECMP_LO = 32'h0000_4000;
  localparam logic [WORD_W-1:0] MTIMECMP_HI = 32'h0000_4004;

  localparam logic [WORD_W-1:0] CMP_PARK = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    RD_HI,
    RD_LO,
    RD_HI2,
    WR_HMAX,
    WR_LO,
    WR_HI,
    WAIT_CLR
  } state_t;

  function automatic logic [WORD_W-1:0] floor_period(input logic [WORD_W-1:0] p,
                                                     input logic [WORD_W-1:0] pmin);
    return (p < pmin) ? pmin : p;
  endfunction

endpackage

// File: rtl/clint_tick_ctrl.sv
// Auto-reloads CLINT mtimecmp to mtime + period on each timer interrupt.
// Optional overrun counter enabled by defining CLINT_TICK_OVERRUN_EN.
module clint_tick_ctrl
  import clint_tick_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PERIOD_MIN = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [WORD_W-1:0]     period_i,
  input  logic                  timer_irq_i,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [DATA_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_data_i,
  output logic [DATA_WIDTH-1:0] cpu_data_o,
  output logic                  cpu_gnt_o,
  output logic                  clint_req_o,
  output logic                  clint_we_o,
  output logic [DATA_WIDTH-1:0] clint_addr_o,
  output logic [DATA_WIDTH-1:0] clint_data_o,
  input  logic [DATA_WIDTH-1:0] clint_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [OVR_W-1:0]      overrun_o
);

  state_t             state;
  state_t             state_next;
  logic [WORD_W-1:0]  hi;
  logic [WORD_W-1:0]  lo;
  logic [WORD_W-1:0]  period_q;
  logic [WORD_W-1:0]  rd_word;
  logic [2*WORD_W-1:0] target;

  assign rd_word = clint_data_i[WORD_W-1:0];
  assign target  = {hi, lo} + (2*WORD_W)'(period_q);

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_next;
  end

  // mtime snapshot, sampled period and status flags
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hi       <= '0;
      lo       <= '0;
      period_q <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      case (state)
        RD_HI:   hi <= rd_word;
        RD_LO: begin
          lo       <= rd_word;
          period_q <= floor_period(period_i, WORD_W'(PERIOD_MIN));
        end
        RD_HI2:  if (rd_word != hi) hi <= rd_word;
        default: ;
      endcase
      busy_o <= (state_next != IDLE);
      done_o <= (state_next == WAIT_CLR) && (state != WAIT_CLR);
    end
  end

  // Next state and bus mux; the CPU owns the CLINT bus only in IDLE
  always_comb begin
    state_next   = state;
    clint_req_o  = 1'b0;
    clint_we_o   = 1'b0;
    clint_addr_o = '0;
    clint_data_o = '0;
    cpu_gnt_o    = 1'b0;
    cpu_data_o   = '0;
    case (state)
      IDLE: begin
        if (rst_i) begin
          clint_req_o  = cpu_req_i;
          clint_we_o   = cpu_we_i;
          clint_addr_o = cpu_addr_i;
          clint_data_o = cpu_data_i;
          cpu_data_o   = clint_data_i;
          cpu_gnt_o    = 1'b1;
        end
        if (en_i && timer_irq_i) state_next = RD_HI;
      end
      RD_HI: begin
        clint_req_o  = 1'b1;
        clint_addr_o = DATA_WIDTH'(MTIME_HI);
        state_next   = RD_LO;
      end
      RD_LO: begin
        clint_req_o  = 1'b1;
        clint_addr_o = DATA_WIDTH'(MTIME_LO);
        state_next   = RD_HI2;
      end
      // A changed high word means lo carried between reads: re-read lo
      RD_HI2: begin
        clint_req_o  = 1'b1;
        clint_addr_o = DATA_WIDTH'(MTIME_HI);
        state_next   = (rd_word != hi) ? RD_LO : WR_HMAX;
      end
      WR_HMAX: begin
        clint_req_o  = 1'b1;
        clint_we_o   = 1'b1;
        clint_addr_o = DATA_WIDTH'(MTIMECMP_HI);
        clint_data_o = DATA_WIDTH'(CMP_PARK);
        state_next   = WR_LO;
      end
      WR_LO: begin
        clint_req_o  = 1'b1;
        clint_we_o   = 1'b1;
        clint_addr_o = DATA_WIDTH'(MTIMECMP_LO);
        clint_data_o = DATA_WIDTH'(target[WORD_W-1:0]);
        state_next   = WR_HI;
      end
      WR_HI: begin
        clint_req_o  = 1'b1;
        clint_we_o   = 1'b1;
        clint_addr_o = DATA_WIDTH'(MTIMECMP_HI);
        clint_data_o = DATA_WIDTH'(target[2*WORD_W-1:WORD_W]);
        state_next   = WAIT_CLR;
      end
      WAIT_CLR: begin
        if (!timer_irq_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef CLINT_TICK_OVERRUN_EN
  logic             irq_q;
  logic [OVR_W-1:0] ovr_cnt;

  // Saturating count of interrupt rising edges arriving mid-reload
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      irq_q   <= 1'b0;
      ovr_cnt <= '0;
    end else begin
      irq_q <= timer_irq_i;
      if (busy_o && timer_irq_i && !irq_q && (ovr_cnt != {OVR_W{1'b1}}))
        ovr_cnt <= ovr_cnt + OVR_W'(1);
    end
  end

  assign overrun_o = ovr_cnt;
`else
  assign overrun_o = '0;
`endif

endmodule

// File: tb/tb_clint_tick_ctrl.sv
// Scoreboard bench for clint_tick_ctrl: a CLINT memory model, expected
// write/done queues filled by the stimulus and drained by a monitor.
module tb_clint_tick_ctrl;
  import clint_tick_ctrl_pkg::*;

  localparam int unsigned DW   = 32;
  localparam int unsigned PMIN = 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0;
  logic [31:0]   period = '0;
  logic          irq = 1'b0;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [DW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_gnt;
  logic          clint_req;
  logic          clint_we;
  logic [DW-1:0] clint_addr;
  logic [DW-1:0] clint_wdata;
  logic [DW-1:0] clint_rdata;
  logic          busy;
  logic          done;
  logic [7:0]    overrun;

  logic [63:0]   mtime = '0;
  logic [63:0]   mtimecmp = '0;
  int            cyc = 0;
  int            n_tests = 0;
  int            n_fail = 0;
  int            ovf_model = 0;
  wr_t           wq[$];
  int            dq[$];
  wr_t           mon_e;
  int            mon_d;

  clint_tick_ctrl #(.DATA_WIDTH(DW), .PERIOD_MIN(PMIN)) dut (
    .clk_i(clk), .rst_i(rst_n), .en_i(en), .period_i(period), .timer_irq_i(irq),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_wdata),
    .cpu_data_o(cpu_rdata), .cpu_gnt_o(cpu_gnt),
    .clint_req_o(clint_req), .clint_we_o(clint_we), .clint_addr_o(clint_addr),
    .clint_data_o(clint_wdata), .clint_data_i(clint_rdata),
    .busy_o(busy), .done_o(done), .overrun_o(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // CLINT register file: combinational read, write at the clock edge
  always_comb begin
    case (clint_addr)
      MTIME_LO:    clint_rdata = mtime[31:0];
      MTIME_HI:    clint_rdata = mtime[63:32];
      MTIMECMP_LO: clint_rdata = mtimecmp[31:0];
      MTIMECMP_HI: clint_rdata = mtimecmp[63:32];
      default:     clint_rdata = '0;
    endcase
  end

  always @(posedge clk) begin
    if (clint_req && clint_we) begin
      if (clint_addr == MTIMECMP_LO) mtimecmp[31:0]  <= clint_wdata;
      if (clint_addr == MTIMECMP_HI) mtimecmp[63:32] <= clint_wdata;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] exp_ovr();
`ifdef CLINT_TICK_OVERRUN_EN
    return (ovf_model > 255) ? 64'd255 : 64'(ovf_model);
`else
    return 64'd0;
`endif
  endfunction

  // Monitor: every CLINT write and every done pulse must match the queues
  always @(negedge clk) begin
    if (clint_req === 1'b1 && clint_we === 1'b1) begin
      if (wq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h, expected none", clint_addr, clint_wdata);
      end else begin
        mon_e = wq.pop_front();
        chk("wr_addr", 64'(clint_addr), 64'(mon_e.addr));
        chk("wr_data", 64'(clint_wdata), 64'(mon_e.data));
      end
    end
    if (done === 1'b1) begin
      if (dq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got pulse at cycle %0d, expected none", cyc);
      end else begin
        mon_d = dq.pop_front();
        chk("done_cycle", 64'(cyc), 64'(mon_d));
      end
    end
  end

  // One cycle: check status mid-cycle, then advance past the next edge
  task automatic step(input bit busy_exp);
    @(negedge clk);
    chk("busy", 64'(busy), 64'(busy_exp));
    if (cpu_req && !cpu_we) begin
      chk("cpu_gnt", 64'(cpu_gnt), 64'(!busy_exp));
      chk("cpu_rdata", 64'(cpu_rdata), busy_exp ? 64'd0 : {32'h0, mtime[31:0]});
    end
    chk("overrun", 64'(overrun), exp_ovr());
    @(posedge clk);
    #1;
  endtask

  // One reload. mtime reads m0 at RD_HI and m1 from RD_LO onward, so a
  // consistent snapshot is m1; the high word changing forces one retry.
  // mode 0: irq held, 1: random irq/en while busy, 2: alternating irq.
  task automatic run_seq(input logic [63:0] m0, input logic [63:0] m1,
                         input logic [31:0] per, input int mode, input bit cpu_rd);
    logic [31:0] pe;
    logic [63:0] tgt;
    int          lat;
    bit          prev;
    bit          cur;
    pe  = (per < 32'(PMIN)) ? 32'(PMIN) : per;
    tgt = m1 + {32'h0, pe};
    lat = (m0[63:32] != m1[63:32]) ? 9 : 7;
    wq.push_back({MTIMECMP_HI, 32'hFFFF_FFFF});
    wq.push_back({MTIMECMP_LO, tgt[31:0]});
    wq.push_back({MTIMECMP_HI, tgt[63:32]});
    mtime    = m0;
    period   = per;
    en       = 1'b1;
    irq      = 1'b1;
    cpu_req  = cpu_rd;
    cpu_we   = 1'b0;
    cpu_addr = MTIME_LO;
    step(1'b0);
    dq.push_back(cyc + lat - 1);
    prev = 1'b1;
    for (int j = 1; j <= lat; j++) begin
      if (j == 2) mtime = m1;
      if (j == lat)       cur = 1'b1;
      else if (mode == 1) cur = 1'($urandom_range(1));
      else if (mode == 2) cur = (j % 2 == 0);
      else                cur = 1'b1;
      if (mode == 1) en = 1'($urandom_range(1));
      irq = cur;
      step(1'b1);
      if (cur && !prev) ovf_model++;
      prev = cur;
    end
    repeat ($urandom_range(2)) step(1'b1);
    irq = 1'b0;
    en  = 1'($urandom_range(1));
    step(1'b1);
    en = 1'b0;
    step(1'b0);
    cpu_req = 1'b0;
    chk("mtimecmp", mtimecmp, tgt);
  endtask

  // Reset lands in WR_LO: only the park write may reach the CLINT
  task automatic reset_mid();
    wq.push_back({MTIMECMP_HI, 32'hFFFF_FFFF});
    mtime   = 64'h0000_0000_0000_5000;
    period  = 32'h80;
    en      = 1'b1;
    irq     = 1'b1;
    cpu_req = 1'b0;
    step(1'b0);
    repeat (4) step(1'b1);
    rst_n = 1'b0;
    ovf_model = 0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_clint_req", 64'(clint_req), 64'd0);
    chk("rst_clint_we", 64'(clint_we), 64'd0);
    @(negedge clk);
    chk("rst_clint_req_next", 64'(clint_req), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    irq   = 1'b0;
    en    = 1'b0;
    rst_n = 1'b1;
    repeat (3) step(1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = MTIMECMP_LO;
    cpu_wdata = 32'h1234_5678;
    en        = 1'b1;
    irq       = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_overrun", 64'(overrun), 64'd0);
    chk("reset_clint_req", 64'(clint_req), 64'd0);
    chk("reset_clint_we", 64'(clint_we), 64'd0);
    chk("reset_clint_addr", 64'(clint_addr), 64'd0);
    chk("reset_clint_data", 64'(clint_wdata), 64'd0);
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    en      = 1'b0;
    irq     = 1'b0;
    rst_n   = 1'b1;
    step(1'b0);

    // CPU write passes straight through in IDLE
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = MTIMECMP_LO;
    cpu_wdata = 32'hCAFE_0001;
    wq.push_back({MTIMECMP_LO, 32'hCAFE_0001});
    step(1'b0);
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    step(1'b0);
    chk("cpu_passthru_wr", {32'h0, mtimecmp[31:0]}, 64'h0000_0000_CAFE_0001);

    run_seq(64'h0000_0000_0000_1000, 64'h0000_0000_0000_1000, 32'h100, 0, 1'b1);
    chk("basic_target", mtimecmp, 64'h0000_0000_0000_1100);
    run_seq(64'h0000_0000_FFFF_FFFF, 64'h0000_0001_0000_0000, 32'h40, 0, 1'b1);
    chk("carry_target", mtimecmp, 64'h0000_0001_0000_0040);
    run_seq(64'hFFFF_FFFF_FFFF_FF00, 64'hFFFF_FFFF_FFFF_FF00, 32'h200, 1, 1'b0);
    chk("wrap_target", mtimecmp, 64'h0000_0000_0000_0100);
    run_seq(64'h0000_0000_0000_0500, 64'h0000_0000_0000_0500, 32'h0, 0, 1'b1);
    chk("floor_target", mtimecmp, 64'h0000_0000_0000_0501);

    reset_mid();

    for (int k = 0; k < 40; k++) begin
      logic [63:0] m0;
      logic [63:0] m1;
      logic [31:0] per;
      m0 = {$urandom, $urandom};
      if ($urandom_range(2) == 0) m0[31:0] = 32'hFFFF_FFFF - 32'($urandom_range(2));
      m1  = m0 + 64'($urandom_range(3));
      per = ($urandom_range(4) == 0) ? 32'h0 : $urandom;
      run_seq(m0, m1, per, int'($urandom_range(1)), 1'($urandom_range(1)));
    end

    // Burst of interrupt edges while busy: three per reload
    for (int k = 0; k < 110; k++) begin
      logic [63:0] m;
      m = {$urandom, 32'h1000_0000};
      run_seq(m, m, 32'h1000, 2, 1'b0);
    end
    step(1'b0);
    chk("overrun_final", 64'(overrun), exp_ovr());

    repeat (3) step(1'b0);
    chk("write_queue_empty", 64'(wq.size()), 64'd0);
    chk("done_queue_empty", 64'(dq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
